fir_coef_ctrl: RTL and testbench

Configuration and sequencing controller in front of the fir datapath. A host stages a new coefficient set into a shadow bank and requests a commit. The controller then stalls the input stream, drains in-flight samples, and writes the coefficients into fir one per cycle. It pulses fir's delay-line clear and resumes streaming, so no output sample ever mixes old and new coefficients.

---
 rtl/fir_coef_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fir_coef_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: stages a coefficient set in a shadow bank and, on commit,
// stalls the sample stream, drains the fir pipeline, writes the coefficients
// one per cycle, clears the fir delay line and resumes streaming.
//
// Handshake: an upstream sample transfers on a cycle where s_valid && s_ready.
// s_ready depends only on the state register, never on inputs. Transferred
// samples appear on fir_in_valid/fir_in_sample exactly one cycle later; fir
// has no back-pressure.
module fir_coef_ctrl #(
  parameter int TAPS          = 10,
  parameter int COEFBITS      = 16,
  parameter int MAXINFLIGHT   = 15,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [$clog2(TAPS)-1:0]  cfg_addr,
  input  logic [COEFBITS-1:0]      cfg_data,
  input  logic                     commit,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     s_valid,
  input  logic [15:0]              s_sample,
  output logic                     s_ready,
  output logic                     fir_in_valid,
  output logic [15:0]              fir_in_sample,
  input  logic                     fir_out_valid,
  output logic                     coef_we,
  output logic [$clog2(TAPS)-1:0]  coef_idx,
  output logic [COEFBITS-1:0]      coef_data,
  output logic                     fir_clear
);

  localparam int AW = $clog2(TAPS);
  localparam int FW = $clog2(MAXINFLIGHT + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [AW:0]   TAPS_W     = (AW + 1)'(TAPS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(TAPS - 1);
  localparam logic [FW-1:0] FLIGHT_MAX = FW'(MAXINFLIGHT);
  localparam logic [TW-1:0] TO_LAST    = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD,
    ST_CLEAR
  } state_t;

  state_t              state;
  logic [COEFBITS-1:0] shadow [TAPS];
  logic [FW-1:0]       flight;
  logic [FW-1:0]       flight_nxt;
  logic                flight_err;
  logic [TW-1:0]       timeout;
  logic                wr_ok;
  logic [AW-1:0]       load_sel;
  logic [COEFBITS-1:0] next_coef;
  logic                drained;
  logic                timeout_hit;
  logic                last_idx;

  assign s_ready = (state == ST_RUN);
  assign busy    = (state != ST_RUN);

  // Shadow writes are blocked while the bank is being streamed into fir.
  assign wr_ok = cfg_wr_en && ({1'b0, cfg_addr} < TAPS_W) && (state != ST_LOAD);

  assign last_idx    = (coef_idx == LAST_IDX);
  assign timeout_hit = (timeout == TO_LAST);

  // Select the coefficient for the next LOAD cycle; a same-cycle shadow write
  // (only possible on the DRAIN->LOAD edge) is bypassed so it is not lost.
  always_comb begin
    load_sel = '0;
    if (state == ST_LOAD && !last_idx) begin
      load_sel = coef_idx + 1'b1;
    end
    next_coef = shadow[load_sel];
    if (wr_ok && cfg_addr == load_sel) begin
      next_coef = cfg_data;
    end
  end

  // In-flight count update with saturation at both ends; either end is an error.
  always_comb begin
    flight_nxt = flight;
    flight_err = 1'b0;
    if (fir_in_valid && !fir_out_valid) begin
      if (flight == FLIGHT_MAX) flight_err = 1'b1;
      else                      flight_nxt = flight + 1'b1;
    end else if (!fir_in_valid && fir_out_valid) begin
      if (flight == '0) flight_err = 1'b1;
      else              flight_nxt = flight - 1'b1;
    end
  end

  // The pipe is empty once this cycle's returns are accounted for.
  assign drained = (flight_nxt == '0) && !fir_in_valid;

  // Shadow bank storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) shadow[i] <= '0;
    end else if (wr_ok) begin
      shadow[cfg_addr] <= cfg_data;
    end
  end

  // One-cycle registered forwarding of accepted samples into fir.
  always_ff @(posedge clk) begin
    if (rst) begin
      fir_in_valid  <= 1'b0;
      fir_in_sample <= '0;
    end else begin
      fir_in_valid  <= s_valid && s_ready;
      fir_in_sample <= s_sample;
    end
  end

  // Commit sequencer with in-flight tracking, drain timeout and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flight    <= '0;
      timeout   <= '0;
      err       <= 1'b0;
      coef_we   <= 1'b0;
      coef_idx  <= '0;
      coef_data <= '0;
      fir_clear <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      fir_clear <= 1'b0;
      flight    <= flight_nxt;
      if (flight_err) err <= 1'b1;
      case (state)
        ST_RUN: begin
          if (commit) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drained || timeout_hit) begin
            if (!drained) err <= 1'b1;
            state     <= ST_LOAD;
            timeout   <= '0;
            coef_we   <= 1'b1;
            coef_idx  <= '0;
            coef_data <= next_coef;
          end else begin
            timeout <= timeout + 1'b1;
          end
        end
        ST_LOAD: begin
          if (last_idx) begin
            state     <= ST_CLEAR;
            coef_we   <= 1'b0;
            fir_clear <= 1'b1;
          end else begin
            coef_idx  <= coef_idx + 1'b1;
            coef_data <= next_coef;
          end
        end
        ST_CLEAR: begin
          state  <= ST_RUN;
          flight <= '0;
          done   <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb_fir_coef_ctrl: directed bench for fir_coef_ctrl with a small fir latency
// model, a coefficient-write scoreboard and a forwarded-sample scoreboard.
module tb_fir_coef_ctrl;

  localparam int TAPS = 10;
  localparam int CB   = 16;
  localparam int AW   = 4;
  localparam int DT   = 8;
  localparam int EW   = AW + CB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CB-1:0] cfg_data = '0;
  logic          commit = 1'b0;
  logic          busy, done, err;
  logic          s_valid = 1'b0;
  logic [15:0]   s_sample = '0;
  logic          s_ready;
  logic          fir_in_valid;
  logic [15:0]   fir_in_sample;
  logic          fir_out_valid;
  logic          coef_we;
  logic [AW-1:0] coef_idx;
  logic [CB-1:0] coef_data;
  logic          fir_clear;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int done_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   fwd_q[$];
  logic [CB-1:0] shadow_m [TAPS];
  logic [EW-1:0] exp_w;
  logic [15:0]   exp_s;

  // fir latency model: out_valid three cycles after in_valid
  logic [2:0] pipe = '0;
  logic       drop_now = 1'b0;
  logic       spur = 1'b0;

  assign fir_out_valid = pipe[2] | spur;

  fir_coef_ctrl #(
    .TAPS(TAPS), .COEFBITS(CB), .MAXINFLIGHT(15), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .commit(commit), .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_sample(s_sample), .s_ready(s_ready),
    .fir_in_valid(fir_in_valid), .fir_in_sample(fir_in_sample),
    .fir_out_valid(fir_out_valid),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .fir_clear(fir_clear)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (rst || fir_clear) pipe <= '0;
    else                  pipe <= {pipe[1:0], fir_in_valid && !drop_now};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (coef_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("coef_we_unexpected", 32'd1, 32'd0);
      else begin
        exp_w = exp_q.pop_front();
        chk("coef_word", 32'({coef_idx, coef_data}), 32'(exp_w));
      end
    end
    if (fir_in_valid === 1'b1) begin
      if (fwd_q.size() == 0) chk("fwd_unexpected", 32'd1, 32'd0);
      else begin
        exp_s = fwd_q.pop_front();
        chk("fwd_sample", 32'(fir_in_sample), 32'(exp_s));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [CB-1:0] data);
    cfg_wr_en = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_data  = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic push_load(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({AW'(k), shadow_m[k]});
  endtask

  task automatic run_to_done(input string tag, input int n);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 60) begin
      tick();
      i++;
    end
    chk(tag, 32'(i), 32'(n));
  endtask

  task automatic send_traffic(input int n, input int drop_at);
    s_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_sample = 16'($urandom_range(0, 65535));
      fwd_q.push_back(s_sample);
      drop_now = (i == drop_at);
      tick();
    end
    drop_now = 1'b0;
  endtask

  int base_we, base_done;

  initial begin
    for (int k = 0; k < TAPS; k++) shadow_m[k] = '0;
    tick();
    tick();
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fir_in_valid", fir_in_valid, 0);
    chk("rst_fir_in_sample", fir_in_sample, 0);
    chk("rst_coef_we", coef_we, 0);
    chk("rst_coef_idx", coef_idx, 0);
    chk("rst_coef_data", coef_data, 0);
    chk("rst_fir_clear", fir_clear, 0);
    rst = 1'b0;
    tick();

    // idle commit with shadow[k]=k+1, second commit in LOAD cycle 4 ignored
    for (int k = 0; k < TAPS; k++) begin
      cfg_write(k, CB'(k + 1));
      shadow_m[k] = CB'(k + 1);
    end
    base_we = we_cnt;
    base_done = done_cnt;
    commit = 1'b1;
    push_load(TAPS);
    tick();
    commit = 1'b0;
    chk("t1_busy_c1", busy, 1);
    chk("t1_s_ready_c1", s_ready, 0);
    chk("t1_coef_we_c1", coef_we, 0);
    tick();
    for (int k = 0; k < TAPS; k++) begin
      chk("t1_load_we", coef_we, 1);
      chk("t1_load_idx", coef_idx, k);
      commit = (k == 4);
      tick();
    end
    chk("t1_clear", fir_clear, 1);
    chk("t1_we_off", coef_we, 0);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_s_ready", s_ready, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_clear_off", fir_clear, 0);
    chk("t1_err", err, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stay_run", busy, 0);
    end
    chk("t5_we_count", 32'(we_cnt - base_we), 32'd10);
    chk("t5_done_count", 32'(done_cnt - base_done), 32'd1);

    // write corner cases: out-of-range addr, write during LOAD
    cfg_write(12, 16'hBEEF);
    commit = 1'b1;
    push_load(TAPS);
    tick();
    commit = 1'b0;
    tick();
    tick();
    cfg_write(3, 16'h1234);
    run_to_done("t4_load_write_done", 9);
    // write during DRAIN reaches the upcoming load
    commit = 1'b1;
    tick();
    commit = 1'b0;
    cfg_wr_en = 1'b1;
    cfg_addr = 4'd3;
    cfg_data = 16'h7FFF;
    shadow_m[3] = 16'h7FFF;
    push_load(TAPS);
    tick();
    cfg_wr_en = 1'b0;
    run_to_done("t4_drain_write_done", 11);

    // commit under traffic
    send_traffic(10, -1);
    s_sample = 16'($urandom_range(0, 65535));
    fwd_q.push_back(s_sample);
    commit = 1'b1;
    push_load(TAPS);
    tick();
    commit = 1'b0;
    s_valid = 1'b0;
    chk("t2_fwd_commit_cycle", fir_in_valid, 1);
    chk("t2_s_ready_off", s_ready, 0);
    for (int j = 1; j <= 4; j++) begin
      chk("t2_no_we_inflight", coef_we, 0);
      tick();
    end
    chk("t2_load_start", coef_we, 1);
    chk("t2_load_idx0", coef_idx, 0);
    run_to_done("t2_done", 11);
    chk("t2_err", err, 0);

    // drain timeout: one sample never returns
    send_traffic(8, 3);
    s_sample = 16'($urandom_range(0, 65535));
    fwd_q.push_back(s_sample);
    commit = 1'b1;
    push_load(TAPS);
    tick();
    commit = 1'b0;
    s_valid = 1'b0;
    for (int j = 1; j < DT; j++) begin
      chk("t3_drain_hold", coef_we, 0);
      tick();
    end
    chk("t3_last_drain_we", coef_we, 0);
    chk("t3_err_before", err, 0);
    tick();
    chk("t3_load_start", coef_we, 1);
    chk("t3_err_set", err, 1);
    run_to_done("t3_done", 11);
    tick();
    tick();
    tick();
    chk("t3_err_sticky", err, 1);

    // reset mid-LOAD at index 5
    commit = 1'b1;
    push_load(6);
    tick();
    commit = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    chk("t6_idx5", coef_idx, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) shadow_m[k] = '0;
    chk("t6_coef_we", coef_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_s_ready", s_ready, 1);
    chk("t6_err", err, 0);
    chk("t6_exp_q_drained", 32'(exp_q.size()), 32'd0);
    commit = 1'b1;
    push_load(TAPS);
    tick();
    commit = 1'b0;
    run_to_done("t6_zero_load_done", 12);
    chk("t6_err_after", err, 0);

    // counter underflow sets err
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("underflow_err", err, 1);

    tick();
    tick();
    chk("final_exp_q", 32'(exp_q.size()), 32'd0);
    chk("final_fwd_q", 32'(fwd_q.size()), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
